// File: rtl/pe_wg_feeder.sv
// pe_wg_feeder: operand sequencer for one PE_WG processing element.
// The host fills a row buffer and a 3-tap weight set while the block is idle.
// A start then streams the row onto the PE operand ports one word per cycle,
// flushes the PE pipeline with zero operands, and pulses done once.
`timescale 1ns/1ps

module pe_wg_feeder #(
    parameter int N      = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int PE_LAT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    // row loader
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [N-1:0] wr_data,
    // weight loader
    input  logic         w_load,
    input  logic [N-1:0] w0_in,
    input  logic [N-1:0] w1_in,
    input  logic [N-1:0] w2_in,
    // job control
    input  logic         mode,
    input  logic         start,
    output logic         busy,
    output logic         done,
    // PE operand interface
    output logic [N-1:0] i0,
    output logic [N-1:0] i1,
    output logic [N-1:0] w0,
    output logic [N-1:0] w1,
    output logic [N-1:0] w2,
    output logic         select0,
    output logic         select1
);

    // Flush counter holds PE_LAT-1 down to 0.
    localparam int CW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    localparam logic [AW:0]   LEN_ONE   = 1;
    localparam logic [AW:0]   LEN_TWO   = 2;
    localparam logic [AW:0]   LEN_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] ADDR_ONE  = 1;
    localparam logic [CW-1:0] FLUSH_TOP = CW'(PE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Job bookkeeping.
    logic [AW:0]   len_reg, len_next;          // words currently buffered
    logic [AW:0]   job_len_reg, job_len_next;  // length frozen at start
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;    // index of the word now on i0
    logic [CW-1:0] flush_cnt_reg, flush_cnt_next;
    logic          mode_reg, mode_next;

    // Registered outputs.
    logic          wr_ready_reg, wr_ready_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [N-1:0]  i0_reg, i0_next;
    logic [N-1:0]  i1_reg, i1_next;
    logic          sel_reg, sel_next;

    // Weight path, one lane per tap.
    logic [2:0][N-1:0] wgt_in;
    logic [2:0][N-1:0] wgt_next;
    logic [2:0][N-1:0] wgt_reg;
    logic [2:0][N-1:0] w_out_next;
    logic [2:0][N-1:0] w_out_reg;

    // Row buffer and its read ports.
    logic [N-1:0]  buf_mem [DEPTH];
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data_a;
    logic [N-1:0]  rd_data_b;

    // Stream-path decode.
    logic          write_en;
    logic          w_load_en;
    logic          stream_valid;   // operand outputs carry row data next cycle
    logic          i1_live;        // the neighbour word exists inside the row

    assign write_en  = (state_reg == S_IDLE) && wr_valid && wr_ready_reg;
    assign w_load_en = (state_reg == S_IDLE) && w_load;

    assign wgt_in[0] = w0_in;
    assign wgt_in[1] = w1_in;
    assign wgt_in[2] = w2_in;

    // Per-tap weight load mux and operand gating.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_wgt
            assign wgt_next[gi]   = w_load_en ? wgt_in[gi] : wgt_reg[gi];
            assign w_out_next[gi] = stream_valid ? wgt_next[gi] : '0;
        end
    endgenerate

    assign rd_data_a = buf_mem[rd_addr];
    assign rd_data_b = buf_mem[rd_addr + ADDR_ONE];

    // Next-state and next-output logic for the job FSM.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        job_len_next   = job_len_reg;
        rd_ptr_next    = rd_ptr_reg;
        flush_cnt_next = flush_cnt_reg;
        mode_next      = mode_reg;
        wr_ready_next  = wr_ready_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        stream_valid   = 1'b0;
        i1_live        = 1'b0;
        rd_addr        = '0;
        sel_next       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (write_en) begin
                    len_next = len_reg + LEN_ONE;
                end
                wr_ready_next = (len_next < LEN_FULL);
                // A start coinciding with a write streams only the words
                // that were already present; the new word is discarded at done.
                if (start && (len_reg != '0)) begin
                    state_next    = S_STREAM;
                    job_len_next  = len_reg;
                    rd_ptr_next   = '0;
                    mode_next     = mode;
                    busy_next     = 1'b1;
                    wr_ready_next = 1'b0;
                    stream_valid  = 1'b1;
                    rd_addr       = '0;
                    i1_live       = (len_reg > LEN_ONE);
                    sel_next      = mode;
                end
            end

            S_STREAM: begin
                if ({1'b0, rd_ptr_reg} == (job_len_reg - LEN_ONE)) begin
                    state_next     = S_FLUSH;
                    flush_cnt_next = FLUSH_TOP;
                end else begin
                    rd_ptr_next  = rd_ptr_reg + ADDR_ONE;
                    stream_valid = 1'b1;
                    rd_addr      = rd_ptr_reg + ADDR_ONE;
                    i1_live      = (({1'b0, rd_ptr_reg} + LEN_TWO) < job_len_reg);
                    sel_next     = mode_reg;
                end
            end

            S_FLUSH: begin
                if (flush_cnt_reg == '0) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    flush_cnt_next = flush_cnt_reg - CW'(1);
                end
            end

            S_DONE: begin
                state_next    = S_IDLE;
                len_next      = '0;
                busy_next     = 1'b0;
                wr_ready_next = 1'b1;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        i0_next = stream_valid ? rd_data_a : '0;
        i1_next = (stream_valid && i1_live) ? rd_data_b : '0;
    end

    // State, bookkeeping and output registers; reset abandons any job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            job_len_reg   <= '0;
            rd_ptr_reg    <= '0;
            flush_cnt_reg <= '0;
            mode_reg      <= 1'b0;
            wr_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            i0_reg        <= '0;
            i1_reg        <= '0;
            sel_reg       <= 1'b0;
            wgt_reg       <= '0;
            w_out_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            job_len_reg   <= job_len_next;
            rd_ptr_reg    <= rd_ptr_next;
            flush_cnt_reg <= flush_cnt_next;
            mode_reg      <= mode_next;
            wr_ready_reg  <= wr_ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            i0_reg        <= i0_next;
            i1_reg        <= i1_next;
            sel_reg       <= sel_next;
            wgt_reg       <= wgt_next;
            w_out_reg     <= w_out_next;
        end
    end

    // Row buffer write port; contents need no reset since len gates every read.
    always_ff @(posedge clk) begin
        if (write_en) begin
            buf_mem[len_reg[AW-1:0]] <= wr_data;
        end
    end

    assign wr_ready = wr_ready_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign i0       = i0_reg;
    assign i1       = i1_reg;
    assign w0       = w_out_reg[0];
    assign w1       = w_out_reg[1];
    assign w2       = w_out_reg[2];
    assign select0  = sel_reg;
    assign select1  = sel_reg;

endmodule

// File: tb/tb_pe_wg_feeder.sv
// tb_pe_wg_feeder: directed table, hand sequences and random jobs checked
// cycle by cycle against a queue-based model of the row and weights.
`timescale 1ns/1ps

module tb_pe_wg_feeder;

    localparam int N      = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int PE_LAT = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [N-1:0] wr_data;
    logic         w_load;
    logic [N-1:0] w0_in, w1_in, w2_in;
    logic         mode;
    logic         start;
    logic         busy, done;
    logic [N-1:0] i0, i1, w0, w1, w2;
    logic         select0, select1;

    pe_wg_feeder #(.N(N), .DEPTH(DEPTH), .AW(AW), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .w_load(w_load), .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in),
        .mode(mode), .start(start), .busy(busy), .done(done),
        .i0(i0), .i1(i1), .w0(w0), .w1(w1), .w2(w2),
        .select0(select0), .select1(select1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: words written since the last job, and current weights.
    logic [7:0] row_q[$];
    logic [7:0] wm0, wm1, wm2;

    // Per-job observations.
    int done_cyc;
    int sel_cnt;
    int acc0, acc1, acc2;

    typedef struct {
        int         nwrite;
        logic [7:0] base;
        bit         m;
        logic [7:0] wa, wb, wc;
        int         exp_done;
        int         exp_sel;
        bit         chk_ps;
        int         e0, e1, e2;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [44:0] obs();
        return {busy, done, wr_ready, select0, select1, i0, i1, w0, w1, w2};
    endfunction

    function automatic logic [44:0] expv(bit b, bit d, bit r, bit s,
                                         logic [7:0] a, logic [7:0] c,
                                         logic [7:0] x, logic [7:0] y, logic [7:0] z);
        return {b, d, r, s, s, a, c, x, y, z};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string name);
        chk(name, 64'(obs()), 64'(expv(1'b0, 1'b0, row_q.size() < DEPTH, 1'b0,
                                       8'h0, 8'h0, 8'h0, 8'h0, 8'h0)));
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        idle_chk("write");
        step();
        if (row_q.size() < DEPTH) row_q.push_back(d);
        wr_valid = 1'b0;
    endtask

    task automatic load_w(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        w_load = 1'b1;
        w0_in = a; w1_in = b; w2_in = c;
        step();
        w_load = 1'b0;
        wm0 = a; wm1 = b; wm2 = c;
    endtask

    // Start a job and follow it through stream, flush and done.
    // inject > 0 pulses every IDLE-only control during that stream cycle.
    task automatic run_job(input bit m, input int inject, input bit wr_with_start);
        logic [7:0] job[$];
        logic [44:0] e;
        int L;
        job = row_q;
        L = job.size();
        mode  = m;
        start = 1'b1;
        wr_valid = wr_with_start;
        wr_data  = 8'h5A;
        idle_chk("pre-start");
        step();
        start = 1'b0;
        wr_valid = 1'b0;
        mode = 1'b0;
        row_q.delete();
        done_cyc = -1;
        sel_cnt = 0;
        acc0 = 0; acc1 = 0; acc2 = 0;
        for (int k = 1; k <= L + PE_LAT + 1; k++) begin
            if (k <= L)
                e = expv(1'b1, 1'b0, 1'b0, m, job[k-1], (k < L) ? job[k] : 8'h0, wm0, wm1, wm2);
            else if (k <= L + PE_LAT)
                e = expv(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
            else
                e = expv(1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
            chk($sformatf("job len %0d cyc %0d", L, k), 64'(obs()), 64'(e));
            if (done && done_cyc < 0) done_cyc = k;
            if (select0 && select1) sel_cnt++;
            acc0 += int'(i0) * int'(w0);
            acc1 += int'(i0) * int'(w1);
            acc2 += int'(i0) * int'(w2);
            if (k == inject) begin
                w_load = 1'b1; w0_in = 8'hEE; w1_in = 8'hEE; w2_in = 8'hEE;
                start = 1'b1; wr_valid = 1'b1; wr_data = 8'h77; mode = ~m;
            end
            step();
            if (k == inject) begin
                w_load = 1'b0; start = 1'b0; wr_valid = 1'b0; mode = 1'b0;
            end
        end
        idle_chk("post-job");
    endtask

    initial begin
        tbl[0] = '{nwrite: 3,  base: 8'd1,  m: 1'b0, wa: 8'd1, wb: 8'd2, wc: 8'd3,
                   exp_done: 8,  exp_sel: 0, chk_ps: 1'b1, e0: 6,   e1: 12,  e2: 18};
        tbl[1] = '{nwrite: 3,  base: 8'd1,  m: 1'b1, wa: 8'd1, wb: 8'd2, wc: 8'd3,
                   exp_done: 8,  exp_sel: 3, chk_ps: 1'b0, e0: 0,   e1: 0,   e2: 0};
        tbl[2] = '{nwrite: 1,  base: 8'd7,  m: 1'b0, wa: 8'd2, wb: 8'd0, wc: 8'd5,
                   exp_done: 6,  exp_sel: 0, chk_ps: 1'b1, e0: 14,  e1: 0,   e2: 35};
        tbl[3] = '{nwrite: 17, base: 8'd16, m: 1'b0, wa: 8'd1, wb: 8'd1, wc: 8'd1,
                   exp_done: 21, exp_sel: 0, chk_ps: 1'b1, e0: 376, e1: 376, e2: 376};

        reset_n = 1'b0;
        wr_valid = 1'b0; wr_data = '0; w_load = 1'b0;
        w0_in = '0; w1_in = '0; w2_in = '0; mode = 1'b0; start = 1'b0;
        wm0 = '0; wm1 = '0; wm2 = '0;
        step();
        idle_chk("in reset");
        step();
        reset_n = 1'b1;
        step();
        idle_chk("after reset");

        // Start with an empty buffer is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        idle_chk("empty start 1");
        step();
        idle_chk("empty start 2");

        // Directed table.
        foreach (tbl[v]) begin
            load_w(tbl[v].wa, tbl[v].wb, tbl[v].wc);
            for (int i = 0; i < tbl[v].nwrite; i++) write_word(tbl[v].base + 8'(i));
            idle_chk("after writes");
            run_job(tbl[v].m, 0, 1'b0);
            chk($sformatf("vec %0d done cycle", v), 64'(done_cyc), 64'(tbl[v].exp_done));
            chk($sformatf("vec %0d select cycles", v), 64'(sel_cnt), 64'(tbl[v].exp_sel));
            if (tbl[v].chk_ps) begin
                chk($sformatf("vec %0d psum0", v), 64'(acc0), 64'(tbl[v].e0));
                chk($sformatf("vec %0d psum1", v), 64'(acc1), 64'(tbl[v].e1));
                chk($sformatf("vec %0d psum2", v), 64'(acc2), 64'(tbl[v].e2));
            end
        end

        // Controls pulsed mid-stream have no effect.
        load_w(8'd3, 8'd5, 8'd7);
        for (int i = 0; i < 5; i++) write_word(8'd10 + 8'(i));
        run_job(1'b0, 2, 1'b0);
        chk("ignored done cycle", 64'(done_cyc), 64'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            idle_chk("no second done");
        end
        write_word(8'd9);
        run_job(1'b0, 0, 1'b0);
        chk("weights kept psum0", 64'(acc0), 64'd27);
        chk("weights kept psum2", 64'(acc2), 64'd63);

        // Asynchronous reset in the middle of a 5-word job.
        for (int i = 0; i < 5; i++) write_word(8'd40 + 8'(i));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pre-reset cyc 1", 64'(obs()),
            64'(expv(1'b1, 1'b0, 1'b0, 1'b0, 8'd40, 8'd41, wm0, wm1, wm2)));
        step();
        reset_n = 1'b0;
        #1;
        row_q.delete();
        wm0 = '0; wm1 = '0; wm2 = '0;
        idle_chk("reset mid-stream");
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            idle_chk("after abort");
        end
        load_w(8'd4, 8'd1, 8'd2);
        write_word(8'd2);
        write_word(8'd3);
        run_job(1'b0, 0, 1'b0);
        chk("fresh job done cycle", 64'(done_cyc), 64'd7);
        chk("fresh job psum0", 64'(acc0), 64'd20);

        // Random jobs against the model.
        for (int r = 0; r < 30; r++) begin
            int n;
            if ($urandom_range(0, 3) == 0)
                load_w(8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                step();
                start = 1'b0;
                idle_chk("rand empty start");
            end
            n = int'($urandom_range(1, DEPTH + 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    step();
                    idle_chk("rand gap");
                end
                write_word(8'($urandom));
            end
            run_job(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
